// File: rtl/sprite_line_buffer.sv
// Double-banked sprite line buffer: renderer owns one bank, composer reads/clears the other; background scrubber zeroes the display tail.
// Reads are 1-cycle registered, no backpressure. Define SPRITE_LINE_BUFFER_FWD_EN for renderer read-after-write forwarding.
module sprite_line_buffer #(
  parameter logic [9:0] SCRUB_START = 10'd640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_render_start,
  input  logic [9:0]  spr_rdidx,
  output logic [15:0] spr_rddata,
  input  logic [9:0]  spr_wridx,
  input  logic [15:0] spr_wrdata,
  input  logic        spr_wren,
  input  logic [9:0]  comp_rdidx,
  input  logic        comp_rden,
  output logic [15:0] comp_rddata,
  output logic        scrub_busy,
  output logic        scrub_overrun
);

  typedef enum logic [1:0] {INIT, IDLE, SCRUB} state_e;

  state_e      state_q;
  logic [9:0]  cnt_q;
  logic        busy_q, overrun_q;
  logic        bank_sel_q;
  logic        clr_vld_q, clr_bank_q;
  logic [9:0]  clr_idx_q;
  logic [15:0] spr_rddata_q, comp_rddata_q;

  logic [15:0] mem0 [1024];
  logic [15:0] mem1 [1024];

  logic init_act, swap, scrub_stall, scrub_wr;
  logic [1:0]        wa_en, wb_en;
  logic [1:0][9:0]   wa_idx, wb_idx;
  logic [1:0][15:0]  wa_dat;
  logic [15:0]       rnd_rd, dsp_rd;

  assign init_act    = (state_q == INIT);
  assign swap        = line_render_start && !init_act;
  // The scrubber only yields when the pending clear lands in the bank it is scrubbing.
  assign scrub_stall = clr_vld_q && (clr_bank_q == ~bank_sel_q);
  assign scrub_wr    = (state_q == SCRUB) && !scrub_stall;

  // Port A carries INIT clears or renderer writes; port B carries composer clears or scrub writes.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wa_en[b]  = init_act || (spr_wren && (bank_sel_q == 1'(b)));
      wa_idx[b] = init_act ? cnt_q : spr_wridx;
      wa_dat[b] = init_act ? 16'h0000 : spr_wrdata;
      wb_en[b]  = !rst && ((clr_vld_q && (clr_bank_q == 1'(b))) ||
                           (scrub_wr && (~bank_sel_q == 1'(b))));
      wb_idx[b] = (clr_vld_q && (clr_bank_q == 1'(b))) ? clr_idx_q : cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_en[0]) mem0[wb_idx[0]] <= 16'h0000;
    if (wa_en[0]) mem0[wa_idx[0]] <= wa_dat[0];
  end

  always_ff @(posedge clk) begin
    if (wb_en[1]) mem1[wb_idx[1]] <= 16'h0000;
    if (wa_en[1]) mem1[wa_idx[1]] <= wa_dat[1];
  end

  assign rnd_rd = bank_sel_q ? mem1[spr_rdidx]  : mem0[spr_rdidx];
  assign dsp_rd = bank_sel_q ? mem0[comp_rdidx] : mem1[comp_rdidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      spr_rddata_q  <= 16'h0000;
      comp_rddata_q <= 16'h0000;
    end else begin
`ifdef SPRITE_LINE_BUFFER_FWD_EN
      if (spr_wren && !init_act && (spr_wridx == spr_rdidx)) spr_rddata_q <= spr_wrdata;
      else                                                  spr_rddata_q <= rnd_rd;
`else
      spr_rddata_q <= rnd_rd;
`endif
      if (comp_rden) comp_rddata_q <= dsp_rd;
    end
  end

  // Clear-on-read remembers the bank at read time so a swap cannot redirect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_q <= 1'b0;
      clr_vld_q  <= 1'b0;
      clr_bank_q <= 1'b0;
      clr_idx_q  <= 10'd0;
    end else begin
      if (swap) bank_sel_q <= ~bank_sel_q;
      clr_vld_q  <= comp_rden;
      clr_bank_q <= ~bank_sel_q;
      clr_idx_q  <= comp_rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= 10'd0;
      busy_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (cnt_q == 10'd1023) begin
            state_q <= IDLE;
            cnt_q   <= 10'd0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        IDLE: begin
          if (swap) begin
            state_q <= SCRUB;
            cnt_q   <= SCRUB_START;
            busy_q  <= 1'b1;
          end
        end
        SCRUB: begin
          if (swap) begin
            cnt_q     <= SCRUB_START;
            overrun_q <= 1'b1;
          end else if (!scrub_stall) begin
            if (cnt_q == 10'd1023) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 10'd1;
            end
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= 10'd0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign spr_rddata    = spr_rddata_q;
  assign comp_rddata   = comp_rddata_q;
  assign scrub_busy    = busy_q;
  assign scrub_overrun = overrun_q;

endmodule

// File: doc/sprite_line_buffer.md
SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 SHALL have parameter SCRUB_START, default 10'd640, meaning the first display-bank index cleared by the background scrubber.
REQ-002 SHALL have ports `clk  in  1  system clock`; all logic is on the rising edge.
REQ-003 SHALL have ports `rst  in  1  reset`; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports `line_render_start  in  1  single-cycle pulse that swaps the banks`.
REQ-005 SHALL have ports `spr_rdidx  in  10`, `spr_rddata  out  16`, `spr_wridx  in  10`, `spr_wrdata  in  16` and `spr_wren  in  1`; these form the renderer-side (render bank) port.
REQ-006 SHALL have ports `comp_rdidx  in  10`, `comp_rden  in  1` and `comp_rddata  out  16`; these form the composer-side (display bank) port.
REQ-007 SHALL have ports `scrub_busy  out  1` (clear in progress) and `scrub_overrun  out  1` (one-cycle pulse when a swap truncates a scrub).

Function
REQ-008 SHALL hold two banks of 1024x16 RAM, bank 0 and bank 1, selected by register bank_sel.
- The render bank is bank[bank_sel].
- The display bank is bank[~bank_sel].
REQ-009 SHALL toggle bank_sel on the cycle after line_render_start, unless INIT is active.
REQ-010 SHALL return spr_rddata = render bank[spr_rdidx] one cycle after spr_rdidx is presented (1-cycle registered read).
REQ-011 SHALL write spr_wrdata to render bank[spr_wridx] on any edge where spr_wren=1 and INIT is not active.
REQ-012 SHALL return comp_rddata = display bank[comp_rdidx] one cycle after a cycle with comp_rden=1.
- comp_rddata holds its value when comp_rden=0.
REQ-013 SHALL clear on read: one cycle after each comp_rden=1 read, write 16'h0000 to the same display-bank index, using the bank selected at read time.
REQ-014 SHALL have a scrubber FSM with states INIT, IDLE and SCRUB.
- INIT: clears index 0..1023 of both banks, one index per cycle (1024 cycles), then enters IDLE.
- IDLE to SCRUB: on each bank swap; the counter loads SCRUB_START.
- SCRUB: writes 0 to display bank[counter], then increments the counter.
- SCRUB to IDLE: after writing index 1023; the counter is a 10-bit value and never wraps past 1023.
REQ-015 SHALL give the composer clear-write priority over the scrubber on the display-bank write port; when the scrubber yields, it stalls and does not advance.
REQ-016 SHALL drive scrub_busy=1 whenever the state is INIT or SCRUB.
REQ-017 SHALL handle a swap that occurs while in SCRUB as follows:
- pulse scrub_overrun for exactly one cycle;
- restart SCRUB at SCRUB_START on the new display bank.
REQ-018 SHALL handle a composer clear-write pending at a swap by completing it to the old display bank, which is now the render bank.
REQ-019 SHALL handle a same-cycle spr_wren and line_render_start by writing to the pre-swap render bank.
REQ-020 SHALL, during INIT, drop spr_wren writes and ignore line_render_start; comp_rddata returns whatever the RAM holds.
REQ-021 SHALL, with SCRUB_START=0, make the scrub cover the full bank (1024 cycles).

Reset
REQ-022 SHALL, on rst=1, set all of the following:
- bank_sel=0;
- spr_rddata=0 and comp_rddata=0;
- scrub_overrun=0;
- scrubber state=INIT with counter=0, so scrub_busy=1 on the first cycle after reset.
REQ-023 SHALL, on rst asserted mid-operation, abort any scrub or pending clear and restart INIT; RAM contents are not otherwise reset.

Configuration
REQ-024 SHALL use macro SPRITE_LINE_BUFFER_FWD_EN to control renderer read-after-write forwarding.
- Defined: if spr_rdidx equals spr_wridx while spr_wren=1 (same render bank), the next-cycle spr_rddata SHALL equal spr_wrdata.
- Undefined: spr_rddata SHALL return the pre-write RAM content, and no forwarding comparator is synthesized.

Verification
REQ-025 SHALL cover reset clear: rst for 1 cycle, then wait; scrub_busy is 1 for 1024 cycles then 0, and all reads of either bank return 0.
REQ-026 SHALL cover write, swap and clear-on-read:
- Stimulus: write 16'h5123 at spr_wridx 100, pulse line_render_start, read comp_rdidx 100, then after the next swap read index 100 via spr_rdidx.
- Response: the comp_rddata read returns 16'h5123, and the later spr_rdidx read returns 16'h0000.
REQ-027 SHALL cover the scrub region:
- Stimulus: write 16'hA0FF at index 700, swap, hold comp_rden=0 for 384 cycles, swap.
- Response: index 700 of the new render bank reads 0; scrub_busy fell after 384 cycles.
REQ-028 SHALL cover scrub stall: comp_rden=1 every cycle during SCRUB gives scrub_busy=1 throughout with the counter frozen; when comp_rden is released, the scrub completes 384 write cycles later.
REQ-029 SHALL cover overrun: a swap 100 cycles into SCRUB gives a one-cycle scrub_overrun=1, and the counter reloads to 640.
REQ-030 SHALL cover forwarding: spr_wren=1 at idx 5 with data 16'h1234 and spr_rdidx=5 in the same cycle gives spr_rddata=16'h1234 with FWD_EN defined, and the old value without it.
